// File: rtl/median_s_axis_fsm.sv
// AXI-Stream slave front end for the median filter: frames incoming pixels,
// checks line/frame structure, and forwards accepted pixels to the line buffers.
module median_s_axis_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic [12:0]           IMG_WIDTH,
    input  logic [12:0]           IMG_HEIGHT,
    input  logic                  i_pause,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] o_pixel,
    output logic                  o_image_data_valid,
    output logic                  o_start_of_frame,
    output logic                  o_frame_done,
    output logic [2:0]            o_err
);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        RECV     = 2'd1,
        DROP     = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [12:0] pixel_cnt, pixel_cnt_nxt;
    logic [12:0] line_cnt, line_cnt_nxt;
    logic        beat;
    logic        last_px;
    logic        last_line;
    logic        fwd_nxt;
    logic        sof_nxt;
    logic        done_nxt;
    logic [2:0]  err_nxt;

    assign s_axis_tready = ~i_pause & ~i_areset;
    assign beat          = s_axis_tvalid & s_axis_tready;
    assign last_px       = (pixel_cnt == (IMG_WIDTH - 13'd1));
    assign last_line     = (line_cnt == (IMG_HEIGHT - 13'd1));

    always_comb begin
        state_nxt     = state;
        pixel_cnt_nxt = pixel_cnt;
        line_cnt_nxt  = line_cnt;
        fwd_nxt       = 1'b0;
        sof_nxt       = 1'b0;
        done_nxt      = 1'b0;
        err_nxt       = 3'b000;

        case (state)
            WAIT_SOF, DROP: begin
                if (beat && s_axis_tuser) begin
                    fwd_nxt       = 1'b1;
                    sof_nxt       = 1'b1;
                    pixel_cnt_nxt = 13'd1;
                    line_cnt_nxt  = 13'd0;
                    state_nxt     = RECV;
                end
            end
            RECV: begin
                if (beat) begin
                    fwd_nxt = 1'b1;
                    // A stray tuser restarts the frame on this very pixel.
                    if (s_axis_tuser) begin
                        sof_nxt       = 1'b1;
                        err_nxt[2]    = 1'b1;
                        pixel_cnt_nxt = 13'd1;
                        line_cnt_nxt  = 13'd0;
                    end else if (last_px && s_axis_tlast) begin
                        pixel_cnt_nxt = 13'd0;
                        if (last_line) begin
                            done_nxt     = 1'b1;
                            line_cnt_nxt = 13'd0;
                            state_nxt    = WAIT_SOF;
                        end else begin
                            line_cnt_nxt = line_cnt + 13'd1;
                        end
                    end else if (!last_px && !s_axis_tlast) begin
                        pixel_cnt_nxt = pixel_cnt + 13'd1;
                    end else begin
                        err_nxt[0]    = s_axis_tlast;
                        err_nxt[1]    = ~s_axis_tlast;
                        pixel_cnt_nxt = 13'd0;
                        line_cnt_nxt  = 13'd0;
                        state_nxt     = DROP;
                    end
                end
            end
            default: begin
                pixel_cnt_nxt = 13'd0;
                line_cnt_nxt  = 13'd0;
                state_nxt     = WAIT_SOF;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state              <= WAIT_SOF;
            pixel_cnt          <= 13'd0;
            line_cnt           <= 13'd0;
            o_pixel            <= '0;
            o_image_data_valid <= 1'b0;
            o_start_of_frame   <= 1'b0;
            o_frame_done       <= 1'b0;
            o_err              <= 3'b000;
        end else begin
            state              <= state_nxt;
            pixel_cnt          <= pixel_cnt_nxt;
            line_cnt           <= line_cnt_nxt;
            if (fwd_nxt) begin
                o_pixel <= s_axis_tdata;
            end
            o_image_data_valid <= fwd_nxt;
            o_start_of_frame   <= sof_nxt;
            o_frame_done       <= done_nxt;
            o_err              <= err_nxt;
        end
    end

endmodule

// File: tb/tb_median_s_axis_fsm.sv
// Directed bench for median_s_axis_fsm: table-driven beats with hand-derived
// outputs, plus hand-written reset and boundary sequences.
module tb_median_s_axis_fsm;

    localparam int DW = 8;

    logic          i_clk = 1'b0;
    logic          i_areset;
    logic [12:0]   IMG_WIDTH;
    logic [12:0]   IMG_HEIGHT;
    logic          i_pause;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tuser;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [DW-1:0] o_pixel;
    logic          o_image_data_valid;
    logic          o_start_of_frame;
    logic          o_frame_done;
    logic [2:0]    o_err;

    median_s_axis_fsm #(.DATA_WIDTH(DW)) dut (
        .i_clk              (i_clk),
        .i_areset           (i_areset),
        .IMG_WIDTH          (IMG_WIDTH),
        .IMG_HEIGHT         (IMG_HEIGHT),
        .i_pause            (i_pause),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tuser       (s_axis_tuser),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tready      (s_axis_tready),
        .o_pixel            (o_pixel),
        .o_image_data_valid (o_image_data_valid),
        .o_start_of_frame   (o_start_of_frame),
        .o_frame_done       (o_frame_done),
        .o_err              (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          valid;
        logic          user;
        logic          last;
        logic          pause;
        logic          e_valid;
        logic [DW-1:0] e_pixel;
        logic          e_sof;
        logic          e_done;
        logic [2:0]    e_err;
    } vec_t;

    vec_t          vecs[$];
    int            n_checks = 0;
    int            n_errors = 0;
    logic [DW-1:0] exp_hold = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected outputs for one beat; o_pixel is expected to hold when not valid.
    task automatic add(input int data, input logic valid, input logic user, input logic last,
                       input logic pause, input logic e_valid, input logic e_sof,
                       input logic e_done, input logic [2:0] e_err);
        vec_t v;
        v.data  = DW'(data);
        v.valid = valid;
        v.user  = user;
        v.last  = last;
        v.pause = pause;
        v.e_valid = e_valid;
        if (e_valid) exp_hold = DW'(data);
        v.e_pixel = exp_hold;
        v.e_sof   = e_sof;
        v.e_done  = e_done;
        v.e_err   = e_err;
        vecs.push_back(v);
    endtask

    task automatic add_frame(input int base, input int w, input int h);
        for (int i = 0; i < w * h; i++) begin
            add(base + i, 1'b1, i == 0, (i % w) == w - 1, 1'b0,
                1'b1, i == 0, i == w * h - 1, 3'b000);
        end
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge i_clk);
            s_axis_tdata  = vecs[i].data;
            s_axis_tvalid = vecs[i].valid;
            s_axis_tuser  = vecs[i].user;
            s_axis_tlast  = vecs[i].last;
            i_pause       = vecs[i].pause;
            #1;
            check({tag, ".tready"}, 32'(s_axis_tready), 32'(!vecs[i].pause));
            @(posedge i_clk);
            #1;
            check({tag, ".valid"}, 32'(o_image_data_valid), 32'(vecs[i].e_valid));
            check({tag, ".pixel"}, 32'(o_pixel),            32'(vecs[i].e_pixel));
            check({tag, ".sof"},   32'(o_start_of_frame),   32'(vecs[i].e_sof));
            check({tag, ".done"},  32'(o_frame_done),       32'(vecs[i].e_done));
            check({tag, ".err"},   32'(o_err),              32'(vecs[i].e_err));
        end
        vecs.delete();
        @(negedge i_clk);
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        i_pause       = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".tready"}, 32'(s_axis_tready),      32'd0);
        check({tag, ".valid"},  32'(o_image_data_valid), 32'd0);
        check({tag, ".pixel"},  32'(o_pixel),            32'd0);
        check({tag, ".sof"},    32'(o_start_of_frame),   32'd0);
        check({tag, ".done"},   32'(o_frame_done),       32'd0);
        check({tag, ".err"},    32'(o_err),              32'd0);
    endtask

    initial begin
        i_areset      = 1'b1;
        IMG_WIDTH     = 13'd4;
        IMG_HEIGHT    = 13'd3;
        i_pause       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        @(negedge i_clk);
        i_areset = 1'b0;

        // Leading non-SOF beats are swallowed, then a clean 4x3 frame.
        add(8'hA0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        add(8'hA1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        add_frame(1, 4, 3);
        run_vecs("frame");

        // Gaps and pause: paused beats must not be taken even with tvalid high.
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 1) add(8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
            if (i % 4 == 2) add(8'hDD, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
            add(20 + i, 1'b1, i == 0, (i % 4) == 3, 1'b0, 1'b1, i == 0, i == 11, 3'b000);
        end
        run_vecs("gaps");

        // Early tlast on the 3rd pixel of line 1, DROP until the next SOF.
        for (int i = 0; i < 7; i++)
            add(40 + i, 1'b1, i == 0, i == 3 || i == 6, 1'b0, 1'b1, i == 0, 1'b0,
                (i == 6) ? 3'b001 : 3'b000);
        add(8'h50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        add(8'h51, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        add_frame(60, 4, 3);
        run_vecs("early");

        // Missing tlast on pixel 4 of line 0; the rest of the frame is dropped.
        for (int i = 0; i < 4; i++)
            add(80 + i, 1'b1, i == 0, 1'b0, 1'b0, 1'b1, i == 0, 1'b0,
                (i == 3) ? 3'b010 : 3'b000);
        for (int i = 4; i < 12; i++)
            add(80 + i, 1'b1, 1'b0, (i % 4) == 3, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        add_frame(100, 4, 3);
        run_vecs("missing");

        // Stray tuser on pixel 6: restart with that pixel as (0,0).
        for (int i = 0; i < 5; i++)
            add(120 + i, 1'b1, i == 0, i == 3, 1'b0, 1'b1, i == 0, 1'b0, 3'b000);
        add(125, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b100);
        for (int i = 1; i < 12; i++)
            add(125 + i, 1'b1, 1'b0, (i % 4) == 3, 1'b0, 1'b1, 1'b0, i == 11, 3'b000);
        run_vecs("tuser");

        // Smallest legal geometry 2x2, changed while idle.
        IMG_WIDTH  = 13'd2;
        IMG_HEIGHT = 13'd2;
        add_frame(150, 2, 2);
        run_vecs("min2x2");
        IMG_WIDTH  = 13'd4;
        IMG_HEIGHT = 13'd3;

        // Reset mid-frame after pixel 5: outputs clear at once, frame resumes only on SOF.
        for (int i = 0; i < 5; i++)
            add(170 + i, 1'b1, i == 0, i == 3, 1'b0, 1'b1, i == 0, 1'b0, 3'b000);
        run_vecs("prerst");
        #2;
        i_areset      = 1'b1;
        s_axis_tdata  = 8'hCC;
        s_axis_tvalid = 1'b1;
        s_axis_tuser  = 1'b1;
        #1;
        check_all_zero("rst_async");
        repeat (2) @(posedge i_clk);
        #1;
        check_all_zero("rst_hold");
        @(negedge i_clk);
        i_areset      = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        exp_hold      = '0;
        add(175, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        add(176, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        add(177, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
        add_frame(200, 4, 3);
        run_vecs("postrst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

endmodule
